// File: rtl/pipe_core_p.sv
// pipe_core_p: five-stage in-order integer pipeline (IF/ID/EX/MEM/WB) with
// EX-stage forwarding, load-use interlock and a run/drain control FSM.
module pipe_core_p #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NREG       = 4,
  parameter int unsigned DMEM_DEPTH = 8,
  parameter int unsigned IMEM_AW    = 5
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     start,
  input  logic [IMEM_AW-1:0]       prog_len,
  output logic [IMEM_AW-1:0]       imem_addr,
  input  logic [31:0]              imem_data,
  input  logic                     cfg_we,
  input  logic [$clog2(NREG)-1:0]  cfg_addr,
  input  logic [DATA_W-1:0]        cfg_wdata,
  input  logic [$clog2(NREG)-1:0]  dbg_sel,
  output logic [DATA_W-1:0]        dbg_rdata,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              stall_cnt,
  output logic [15:0]              retired
);
  localparam int unsigned RW = $clog2(NREG);
  localparam int unsigned AW = $clog2(DMEM_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;
  typedef enum logic [2:0] {OP_NOP, OP_ADD, OP_SUB, OP_SLA, OP_SRA, OP_LD, OP_ST} op_e;

  // architectural state
  logic [DATA_W-1:0]  r_rf   [NREG];
  logic [DATA_W-1:0]  r_dmem [DMEM_DEPTH];

  // control
  state_e             r_state;
  logic [IMEM_AW-1:0] r_pc, r_len;
  logic [1:0]         r_drain_cnt;
  logic               r_busy, r_done;
  logic [15:0]        r_stall_cnt, r_retired;

  // IF/ID (only the fields the decoder uses; rt is the low bits of imm)
  logic               r_ifid_valid;
  logic [7:0]         r_ifid_opc, r_ifid_imm;
  logic [RW-1:0]      r_ifid_rs, r_ifid_rd;

  // ID/EX
  logic               r_idex_valid, r_idex_we;
  op_e                r_idex_op;
  logic [RW-1:0]      r_idex_rs, r_idex_rt, r_idex_dst;
  logic [7:0]         r_idex_imm;
  logic [DATA_W-1:0]  r_idex_a, r_idex_b;

  // EX/MEM
  logic               r_exmem_valid, r_exmem_we;
  op_e                r_exmem_op;
  logic [RW-1:0]      r_exmem_dst;
  logic [DATA_W-1:0]  r_exmem_res, r_exmem_sdata;
  logic [AW-1:0]      r_exmem_addr;

  // MEM/WB
  logic               r_memwb_valid, r_memwb_we;
  logic [RW-1:0]      r_memwb_dst;
  logic [DATA_W-1:0]  r_memwb_res;

  logic               w_unused;
  op_e                w_op;
  logic [RW-1:0]      w_rt, w_dst;
  logic               w_id_we, w_uses_rs, w_uses_rt, w_stall, w_pipe_empty, w_last_fetch;
  logic               w_exmem_fwd, w_memwb_fwd, w_imm_big;
  logic [DATA_W-1:0]  w_id_a, w_id_b, w_fwd_a, w_fwd_b, w_alu, w_mem_res;

  assign w_unused     = ^{imem_data[23:16+RW], imem_data[7:RW]};
  assign imem_addr    = r_pc;
  assign busy         = r_busy;
  assign done         = r_done;
  assign stall_cnt    = r_stall_cnt;
  assign retired      = r_retired;
  assign dbg_rdata    = r_rf[dbg_sel];
  assign w_pipe_empty = !(r_ifid_valid || r_idex_valid || r_exmem_valid || r_memwb_valid);
  assign w_last_fetch = (r_pc == r_len - IMEM_AW'(1));
  assign w_exmem_fwd  = r_exmem_valid && r_exmem_we && (r_exmem_op != OP_LD);
  assign w_memwb_fwd  = r_memwb_valid && r_memwb_we;
  assign w_imm_big    = (32'(r_idex_imm) >= DATA_W);
  assign w_rt         = r_ifid_imm[RW-1:0];

  // Decode the instruction in ID; unknown opcodes behave as NOP
  always_comb begin
    w_op = OP_NOP;
    case (r_ifid_opc)
      8'h20:   w_op = OP_ADD;
      8'h10:   w_op = OP_SUB;
      8'h08:   w_op = OP_SLA;
      8'h04:   w_op = OP_SRA;
      8'h40:   w_op = OP_ST;
      8'h80:   w_op = OP_LD;
      default: w_op = OP_NOP;
    endcase
    w_uses_rs = (w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_SLA) || (w_op == OP_SRA);
    w_uses_rt = (w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_ST);
    w_id_we   = w_uses_rs || (w_op == OP_LD);
    w_dst     = (w_op == OP_LD) ? w_rt : r_ifid_rd;
  end

  // Register read in ID with write-through from the WB stage
  always_comb begin
    w_id_a = r_rf[r_ifid_rs];
    w_id_b = r_rf[w_rt];
    if (w_memwb_fwd && (r_memwb_dst == r_ifid_rs)) w_id_a = r_memwb_res;
    if (w_memwb_fwd && (r_memwb_dst == w_rt))      w_id_b = r_memwb_res;
  end

  // Load-use interlock: LOAD in EX feeding an operand of the ID instruction
  always_comb begin
    w_stall = r_ifid_valid && r_idex_valid && (r_idex_op == OP_LD) &&
              ((w_uses_rs && (r_idex_dst == r_ifid_rs)) || (w_uses_rt && (r_idex_dst == w_rt)));
  end

  // EX operand forwarding: EX/MEM beats MEM/WB beats the ID/EX copy
  always_comb begin
    w_fwd_a = r_idex_a;
    w_fwd_b = r_idex_b;
    if (w_memwb_fwd && (r_memwb_dst == r_idex_rs)) w_fwd_a = r_memwb_res;
    if (w_memwb_fwd && (r_memwb_dst == r_idex_rt)) w_fwd_b = r_memwb_res;
    if (w_exmem_fwd && (r_exmem_dst == r_idex_rs)) w_fwd_a = r_exmem_res;
    if (w_exmem_fwd && (r_exmem_dst == r_idex_rt)) w_fwd_b = r_exmem_res;
  end

  // ALU; oversized shifts saturate to zero or sign fill
  always_comb begin
    w_alu = '0;
    case (r_idex_op)
      OP_ADD:  w_alu = w_fwd_a + w_fwd_b;
      OP_SUB:  w_alu = w_fwd_a - w_fwd_b;
      OP_SLA:  w_alu = w_imm_big ? '0 : (w_fwd_a << r_idex_imm);
      OP_SRA:  w_alu = w_imm_big ? {DATA_W{w_fwd_a[DATA_W-1]}}
                                 : DATA_W'($unsigned($signed(w_fwd_a) >>> r_idex_imm));
      default: w_alu = '0;
    endcase
  end

  // MEM result: load data or the ALU value passing through
  assign w_mem_res = (r_exmem_op == OP_LD) ? r_dmem[r_exmem_addr] : r_exmem_res;

  // Control FSM: fetch sequencing, drain detection, run statistics
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_len       <= '0;
      r_drain_cnt <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_stall_cnt <= '0;
      r_retired   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pc        <= '0;
            r_len       <= prog_len;
            r_drain_cnt <= '0;
            r_stall_cnt <= '0;
            r_retired   <= '0;
            if (prog_len != '0) begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end else begin
              r_done  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (!w_stall) begin
            if (w_last_fetch) r_state <= S_DRAIN;
            else              r_pc    <= r_pc + IMEM_AW'(1);
          end
        end
        S_DRAIN: begin
          if (w_pipe_empty) begin
            if (r_drain_cnt == 2'd3) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_drain_cnt <= r_drain_cnt + 2'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (r_state != S_IDLE) begin
        if (w_stall && (r_stall_cnt != 16'hFFFF))       r_stall_cnt <= r_stall_cnt + 16'd1;
        if (r_memwb_valid && (r_retired != 16'hFFFF))   r_retired   <= r_retired + 16'd1;
      end
    end
  end

  // Pipeline registers; a stall holds IF/ID and sends a bubble into EX
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ifid_valid  <= 1'b0;
      r_ifid_opc    <= '0;
      r_ifid_imm    <= '0;
      r_ifid_rs     <= '0;
      r_ifid_rd     <= '0;
      r_idex_valid  <= 1'b0;
      r_idex_we     <= 1'b0;
      r_idex_op     <= OP_NOP;
      r_idex_rs     <= '0;
      r_idex_rt     <= '0;
      r_idex_dst    <= '0;
      r_idex_imm    <= '0;
      r_idex_a      <= '0;
      r_idex_b      <= '0;
      r_exmem_valid <= 1'b0;
      r_exmem_we    <= 1'b0;
      r_exmem_op    <= OP_NOP;
      r_exmem_dst   <= '0;
      r_exmem_res   <= '0;
      r_exmem_sdata <= '0;
      r_exmem_addr  <= '0;
      r_memwb_valid <= 1'b0;
      r_memwb_we    <= 1'b0;
      r_memwb_dst   <= '0;
      r_memwb_res   <= '0;
    end else begin
      if (!w_stall) begin
        r_ifid_valid <= (r_state == S_RUN);
        r_ifid_opc   <= imem_data[31:24];
        r_ifid_rs    <= imem_data[16 +: RW];
        r_ifid_imm   <= imem_data[15:8];
        r_ifid_rd    <= imem_data[RW-1:0];
      end
      r_idex_valid  <= r_ifid_valid && !w_stall;
      r_idex_we     <= r_ifid_valid && !w_stall && w_id_we;
      r_idex_op     <= w_op;
      r_idex_rs     <= r_ifid_rs;
      r_idex_rt     <= w_rt;
      r_idex_dst    <= w_dst;
      r_idex_imm    <= r_ifid_imm;
      r_idex_a      <= w_id_a;
      r_idex_b      <= w_id_b;
      r_exmem_valid <= r_idex_valid;
      r_exmem_we    <= r_idex_we;
      r_exmem_op    <= r_idex_op;
      r_exmem_dst   <= r_idex_dst;
      r_exmem_res   <= w_alu;
      r_exmem_sdata <= w_fwd_b;
      r_exmem_addr  <= r_idex_imm[AW-1:0];
      r_memwb_valid <= r_exmem_valid;
      r_memwb_we    <= r_exmem_we;
      r_memwb_dst   <= r_exmem_dst;
      r_memwb_res   <= w_mem_res;
    end
  end

  // Register file and data memory; reset wins over any in-flight write
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < int'(NREG); i++)       r_rf[i]   <= '0;
      for (int i = 0; i < int'(DMEM_DEPTH); i++) r_dmem[i] <= DATA_W'(i - 3);
    end else begin
      if (w_memwb_fwd)                     r_rf[r_memwb_dst] <= r_memwb_res;
      else if (cfg_we && (r_state == S_IDLE)) r_rf[cfg_addr] <= cfg_wdata;
      if (r_exmem_valid && (r_exmem_op == OP_ST)) r_dmem[r_exmem_addr] <= r_exmem_sdata;
    end
  end

endmodule

// File: tb/tb_pipe_core_p.sv
// tb_pipe_core_p: directed programs; expected end-of-run state is queued at
// start, and a monitor compares it when the core signals done.
module tb_pipe_core_p;
  localparam int unsigned DATA_W = 32, NREG = 4, DMEM_DEPTH = 8, IMEM_AW = 5;

  typedef struct {
    logic [3:0][31:0] regs;
    int               stall;
    int               ret;
    int               done_cyc;
  } exp_t;

  logic               CLK = 1'b0;
  logic               RST, start, cfg_we, busy, done;
  logic [IMEM_AW-1:0] prog_len, imem_addr;
  logic [31:0]        imem_data, cfg_wdata, dbg_rdata;
  logic [1:0]         cfg_addr, dbg_sel;
  logic [15:0]        stall_cnt, retired;
  logic [31:0]        prog_mem [32];

  exp_t sb [$];
  int   cyc = 0, n_checks = 0, n_pass = 0, n_exp = 0, n_mon = 0;

  pipe_core_p #(.DATA_W(DATA_W), .NREG(NREG), .DMEM_DEPTH(DMEM_DEPTH), .IMEM_AW(IMEM_AW)) dut (
    .CLK(CLK), .RST(RST), .start(start), .prog_len(prog_len),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .dbg_sel(dbg_sel), .dbg_rdata(dbg_rdata),
    .busy(busy), .done(done), .stall_cnt(stall_cnt), .retired(retired)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  assign imem_data = prog_mem[imem_addr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic do_reset();
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge CLK); cfg_we = 1'b1; cfg_addr = 2'(idx); cfg_wdata = val;
    @(negedge CLK); cfg_we = 1'b0;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 32; i++) prog_mem[i] = 32'h0;
  endtask

  // Start a program, queue its expected end state, wait for the monitor.
  // lat = cycles from start acceptance to the done pulse.
  task automatic run_prog(input int len, input logic [31:0] e0, e1, e2, e3,
                          input int st, input int rt, input int lat, input bit poke);
    exp_t e;
    int   k;
    @(negedge CLK); prog_len = IMEM_AW'(len); start = 1'b1;
    @(posedge CLK); #1; k = cyc;
    e.regs = {e3, e2, e1, e0};
    e.stall = st; e.ret = rt; e.done_cyc = k + lat;
    sb.push_back(e); n_exp++;
    @(negedge CLK); start = 1'b0;
    if (poke) begin
      // start and cfg_we while busy must both be ignored
      @(negedge CLK); start = 1'b1; prog_len = 5'd3;
      cfg_we = 1'b1; cfg_addr = 2'd3; cfg_wdata = 32'hDEAD;
      @(negedge CLK); start = 1'b0; cfg_we = 1'b0;
    end
    for (int i = 0; i < 200 && n_mon < n_exp; i++) @(negedge CLK);
    chk("done_seen", 64'(n_mon), 64'(n_exp));
    if (n_mon < n_exp) begin
      sb.delete();
      n_mon = n_exp;
    end
  endtask

  // Monitor: on each done pulse pop the expected state and compare
  initial begin
    exp_t e;
    dbg_sel = '0;
    forever begin
      @(negedge CLK);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
          chk("busy_at_done", 64'(busy), 64'd0);
          chk("stall_cnt", 64'(stall_cnt), 64'(e.stall));
          chk("retired", 64'(retired), 64'(e.ret));
          for (int r = 0; r < 4; r++) begin
            dbg_sel = 2'(r); #1;
            chk($sformatf("reg_r%0d", r), 64'(dbg_rdata), 64'(e.regs[r]));
          end
          @(negedge CLK);
          chk("done_one_cycle", 64'(done), 64'd0);
          @(negedge CLK);
          chk("stall_cnt_hold", 64'(stall_cnt), 64'(e.stall));
          chk("retired_hold", 64'(retired), 64'(e.ret));
          n_mon++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  // Stimulus
  initial begin
    RST = 1'b1; start = 1'b0; prog_len = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    clear_prog();
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("rst_retired", 64'(retired), 64'd0);
    chk("rst_imem_addr", 64'(imem_addr), 64'd0);

    // single ADD; busy-time start/cfg_we ignored; done after 5 + 4 drain
    preload(0, 32'd5); preload(1, 32'd7);
    clear_prog();
    prog_mem[0] = 32'h20_00_01_02;                 // ADD r2 = r0 + r1
    run_prog(1, 32'd5, 32'd7, 32'd12, 32'd0, 0, 1, 9, 1'b1);

    // back-to-back dependency through EX/MEM; counters restart from 0
    prog_mem[1] = 32'h10_02_00_03;                 // SUB r3 = r2 - r0
    run_prog(2, 32'd5, 32'd7, 32'd12, 32'd7, 0, 2, 10, 1'b0);

    // load-use stall; rt overlaps imm, so LOAD imm=6 targets r2
    do_reset();
    clear_prog();
    prog_mem[0] = 32'h80_00_06_00;                 // LOAD r2 = dmem[6] (=3)
    prog_mem[1] = 32'h20_02_02_03;                 // ADD r3 = r2 + r2
    run_prog(2, 32'd0, 32'd0, 32'd3, 32'd6, 1, 2, 11, 1'b0);

    // arithmetic shift right, oversized shifts
    preload(0, 32'hFFFF_FFF0);
    clear_prog();
    prog_mem[0] = 32'h04_00_01_01;                 // SRA r1 = r0 >>> 1
    prog_mem[1] = 32'h08_00_28_02;                 // SLA r2 = r0 << 40
    prog_mem[2] = 32'h04_00_28_03;                 // SRA r3 = r0 >>> 40
    run_prog(3, 32'hFFFF_FFF0, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFFF, 0, 3, 11, 1'b0);

    // store forwarding, store/load round trip, stall feeding from load data
    do_reset();
    preload(0, 32'd5); preload(1, 32'd7);
    clear_prog();
    prog_mem[0] = 32'h20_00_01_02;                 // ADD r2 = r0 + r1 (12)
    prog_mem[1] = 32'h40_00_02_00;                 // STORE dmem[2] = r2
    prog_mem[2] = 32'h20_00_00_02;                 // ADD r2 = r0 + r0 (10)
    prog_mem[3] = 32'h80_00_02_00;                 // LOAD r2 = dmem[2] (12)
    prog_mem[4] = 32'h20_02_01_03;                 // ADD r3 = r2 + r1 (19)
    run_prog(5, 32'd5, 32'd7, 32'd12, 32'd19, 1, 5, 14, 1'b0);

    // unknown opcode and NOP retire; SLA does not read rt so no stall
    do_reset();
    preload(0, 32'd3);
    clear_prog();
    prog_mem[0] = 32'h55_00_00_00;                 // unknown -> NOP
    prog_mem[1] = 32'h80_00_05_00;                 // LOAD r1 = dmem[5] (=2)
    prog_mem[2] = 32'h08_00_01_03;                 // SLA r3 = r0 << 1
    prog_mem[3] = 32'h00_00_00_00;                 // NOP
    run_prog(4, 32'd3, 32'd2, 32'd0, 32'd6, 0, 4, 12, 1'b0);

    // empty program: done the cycle after start, counters cleared
    preload(0, 32'd9);
    run_prog(0, 32'd9, 32'd2, 32'd0, 32'd6, 0, 0, 0, 1'b0);

    // reset two cycles into a run aborts it without writes or done
    do_reset();
    preload(0, 32'd5); preload(1, 32'd7);
    clear_prog();
    prog_mem[0] = 32'h20_00_01_02;
    @(negedge CLK); prog_len = 5'd1; start = 1'b1;
    @(negedge CLK); start = 1'b0;
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_imem_addr", 64'(imem_addr), 64'd0);
    chk("abort_retired", 64'(retired), 64'd0);
    repeat (20) @(negedge CLK);
    chk("abort_busy_later", 64'(busy), 64'd0);
    run_prog(0, 32'd0, 32'd0, 32'd0, 32'd0, 0, 0, 0, 1'b0);

    repeat (2) @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
